// File: rtl/coin_inventory_if.sv
// Coin inventory bus: acceptor strobes, change request
// and the counts/flags/dispense pulses it gets back.
interface coin_inventory_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int AMT_W  = 10
);
  logic                    enable;
  logic [NUM_CH-1:0]       inc_sig;
  logic [NUM_CH-1:0]       dec_sig;
  logic [NUM_CH*WIDTH-1:0] coins;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       empty;
  logic                    chg_req;
  logic [AMT_W-1:0]        chg_amount;
  logic                    chg_busy;
  logic [NUM_CH-1:0]       disp_coin;
  logic                    chg_done;
  logic                    chg_fail;
  logic [AMT_W-1:0]        chg_remaining;

  modport master (
    output enable,
    output inc_sig,
    output dec_sig,
    output chg_req,
    output chg_amount,
    input  coins,
    input  full,
    input  empty,
    input  chg_busy,
    input  disp_coin,
    input  chg_done,
    input  chg_fail,
    input  chg_remaining
  );

  modport slave (
    input  enable,
    input  inc_sig,
    input  dec_sig,
    input  chg_req,
    input  chg_amount,
    output coins,
    output full,
    output empty,
    output chg_busy,
    output disp_coin,
    output chg_done,
    output chg_fail,
    output chg_remaining
  );
endinterface

// File: rtl/coin_inventory.sv
// Per-denomination saturating coin counters with a
// greedy one-coin-per-two-cycles change dispenser.
module coin_inventory #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int VAL_W  = 8,
  parameter int AMT_W  = 10,
  parameter logic [NUM_CH*VAL_W-1:0] COIN_VALUES =
    {8'd1, 8'd5, 8'd10, 8'd25}
) (
  input  logic          CLK,
  input  logic          reset,
  coin_inventory_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DISPENSE,
    DONE,
    FAIL
  } state_e;

  function automatic logic [AMT_W-1:0] coin_val(
    input int i
  );
    return AMT_W'(COIN_VALUES[i*VAL_W +: VAL_W]);
  endfunction

  state_e              state_q;
  logic [AMT_W-1:0]    rem_q;
  logic [CH_W-1:0]     sel_q;
  logic                busy_q;
  logic [NUM_CH-1:0]   disp_q;
  logic                done_q;
  logic                fail_q;

  logic [WIDTH-1:0]    cnt_q [NUM_CH];
  logic [WIDTH-1:0]    cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   inc_eff;
  logic [NUM_CH-1:0]   dec_eff;

  logic                found;
  logic [CH_W-1:0]     pick;

  // Downward walk so the lowest (highest-value) index wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (cnt_q[i] != '0 && coin_val(i) <= rem_q) begin
        found = 1'b1;
        pick  = CH_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      inc_eff[i] = bus.enable & bus.inc_sig[i];
      dec_eff[i] = (state_q == DISPENSE &&
                    sel_q == CH_W'(i)) |
                   (bus.dec_sig[i] & ~busy_q);
      cnt_d[i] = cnt_q[i];
      if (inc_eff[i] && !dec_eff[i]) begin
        if (cnt_q[i] != CNT_MAX)
          cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_eff[i] && !inc_eff[i]) begin
        if (cnt_q[i] != '0)
          cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      disp_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      disp_q <= '0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.chg_req) begin
            rem_q   <= bus.chg_amount;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (rem_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (found) begin
            sel_q   <= pick;
            disp_q  <= NUM_CH'(1) << pick;
            state_q <= DISPENSE;
          end else begin
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
            state_q <= FAIL;
          end
        end
        DISPENSE: begin
          rem_q   <= rem_q - coin_val(int'(sel_q));
          state_q <= SCAN;
        end
        DONE:    state_q <= IDLE;
        FAIL:    state_q <= IDLE;
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.coins[g*WIDTH +: WIDTH] = cnt_q[g];
    assign bus.full[g]  = (cnt_q[g] == CNT_MAX);
    assign bus.empty[g] = (cnt_q[g] == '0);
  end

  assign bus.chg_busy      = busy_q;
  assign bus.disp_coin     = disp_q;
  assign bus.chg_done      = done_q;
  assign bus.chg_fail      = fail_q;
  assign bus.chg_remaining = rem_q;

endmodule
